axil_wr_responder: RTL and testbench

AXI4-Lite write-channel responder that sits behind the interconnect as the slave end of the write path driven by the AXI VIP masters. It buffers AW and W beats independently, pairs them in order, and decodes against a BRAM window at 0x4000_0000. Valid writes go out on a simple word-addressed memory port, and every pair gets a B response. An optional flood guard rejects write storms that would otherwise starve other masters.

---
 rtl/axil_resp_pkg.sv | 16 +
 rtl/axil_wr_responder_if.sv | 34 +++
 rtl/axil_sync_fifo.sv | 53 +++++
 rtl/axil_wr_responder.sv | 190 +++++++++++++++++++
 tb/tb_axil_wr_responder.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_resp_pkg.sv
// ---------------------------------------------------------------------------
// axil_resp_pkg
// Shared definitions for the AXI4-Lite write responder: the B-channel
// response codes and the default base address of the BRAM decode window.
// ---------------------------------------------------------------------------
package axil_resp_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

endpackage

// File: rtl/axil_wr_responder_if.sv
// ---------------------------------------------------------------------------
// axil_wr_if
// AXI4-Lite write-path bundle (AW, W and B channels, no read channel).
//   master modport : drives awvalid/awaddr/awprot, wvalid/wdata/wstrb, bready
//   slave modport  : drives awready, wready, bvalid/bresp
// ---------------------------------------------------------------------------
interface axil_wr_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic [2:0]            awprot;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output awready, wready, bvalid, bresp
  );

endinterface

// File: rtl/axil_sync_fifo.sv
// ---------------------------------------------------------------------------
// axil_sync_fifo
// Single-clock FIFO with full/empty flags. Pushes while full and pops while
// empty are ignored. Storage is not reset; only the pointers are.
//   clk, rst (sync, active-high)
//   push, din  : write side
//   pop, dout  : read side, dout shows the current head (first-word fall-through)
//   full, empty: status flags
// ---------------------------------------------------------------------------
module axil_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = store[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/axil_wr_responder.sv
// ---------------------------------------------------------------------------
// axil_wr_responder
// AXI4-Lite write responder. AW and W beats are buffered in separate FIFOs,
// paired in arrival order, decoded against the BRAM window and turned into a
// one-cycle memory write plus a B response.
//   clk_100MHz, reset_rtl_0 (sync, active-high)
//   s_axi           : axil_wr_if.slave (AW, W, B channels)
//   mem_we          : one-cycle write pulse per OKAY write
//   mem_addr        : word index (awaddr - BASE_ADDR) >> 2
//   mem_wdata/wstrb : write data and byte strobes
//   flood_active    : flood guard tripped for the current window
//   drop_count      : saturating count of guard-rejected writes
// Optional feature macro: AXIL_FLOOD_GUARD_EN enables the flood guard; when
// undefined, flood_active/drop_count are tied low and no counters exist.
// ---------------------------------------------------------------------------
module axil_wr_responder
  import axil_resp_pkg::*;
#(
  parameter int              ADDR_W       = 32,
  parameter int              DATA_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(DEFAULT_BASE_ADDR),
  parameter int              MEM_WORDS    = 2048,
  parameter int              FIFO_DEPTH   = 4,
  parameter int              FLOOD_WINDOW = 256,
  parameter int              FLOOD_LIMIT  = 64,
  localparam int             MEM_AW       = $clog2(MEM_WORDS),
  localparam int             STRB_W       = DATA_W / 8
) (
  input  logic              clk_100MHz,
  input  logic              reset_rtl_0,
  axil_wr_if.slave          s_axi,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic              flood_active,
  output logic [15:0]       drop_count
);

  localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(4 * MEM_WORDS);

  logic                     ready_en;
  logic                     aw_full, aw_empty, w_full, w_empty;
  logic                     aw_push, w_push, commit;
  logic [ADDR_W+2:0]        aw_dout;
  logic [DATA_W+STRB_W-1:0] w_dout;
  logic [ADDR_W-1:0]        head_addr;
  logic [2:0]               head_prot;
  logic [DATA_W-1:0]        head_data;
  logic [STRB_W-1:0]        head_strb;
  logic [ADDR_W-1:0]        offset;
  logic                     in_range, aligned, guard_block, write_ok;
  logic                     bvalid_q;
  resp_e                    bresp_q, resp_c;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Ready is held low through reset and rises the cycle after it releases.
  always_ff @(posedge clk_100MHz) begin
    if (reset_rtl_0) ready_en <= 1'b0;
    else             ready_en <= 1'b1;
  end

  assign s_axi.awready = ready_en && !aw_full;
  assign s_axi.wready  = ready_en && !w_full;
  assign aw_push       = s_axi.awvalid && s_axi.awready;
  assign w_push        = s_axi.wvalid && s_axi.wready;

  axil_sync_fifo #(.WIDTH(ADDR_W + 3), .DEPTH(FIFO_DEPTH)) u_aw_fifo (
    .clk   (clk_100MHz),
    .rst   (reset_rtl_0),
    .push  (aw_push),
    .din   ({s_axi.awaddr, s_axi.awprot}),
    .pop   (commit),
    .dout  (aw_dout),
    .full  (aw_full),
    .empty (aw_empty)
  );

  axil_sync_fifo #(.WIDTH(DATA_W + STRB_W), .DEPTH(FIFO_DEPTH)) u_w_fifo (
    .clk   (clk_100MHz),
    .rst   (reset_rtl_0),
    .push  (w_push),
    .din   ({s_axi.wdata, s_axi.wstrb}),
    .pop   (commit),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  assign {head_addr, head_prot} = aw_dout;
  assign {head_data, head_strb} = w_dout;

  // Pair heads only when the single-entry B register is free or draining.
  assign commit   = !aw_empty && !w_empty && (!bvalid_q || s_axi.bready);

  assign in_range = ({1'b0, head_addr} >= WIN_LO) && ({1'b0, head_addr} < WIN_HI);
  assign aligned  = (head_addr[1:0] == 2'b00);
  assign offset   = head_addr - BASE_ADDR;

`ifdef AXIL_FLOOD_GUARD_EN
  localparam int WIN_W = (FLOOD_WINDOW > 1) ? $clog2(FLOOD_WINDOW) : 1;
  localparam int CNT_W = $clog2(FLOOD_LIMIT + 1);

  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] commit_cnt, cnt_base;
  logic             wrap, flood_q, flood_base, hit, flood_eff, drop;
  logic [15:0]      drop_q;

  // In the wrap cycle the decision already belongs to the new window.
  assign wrap        = (win_cnt == WIN_W'(FLOOD_WINDOW - 1));
  assign cnt_base    = wrap ? '0 : commit_cnt;
  assign flood_base  = wrap ? 1'b0 : flood_q;
  assign hit         = (int'(cnt_base) + 1) >= FLOOD_LIMIT;
  assign flood_eff   = flood_base || hit;
  assign guard_block = flood_eff && !head_prot[0];
  assign drop        = commit && in_range && aligned && guard_block;

  always_ff @(posedge clk_100MHz) begin
    if (reset_rtl_0) begin
      win_cnt    <= '0;
      commit_cnt <= '0;
      flood_q    <= 1'b0;
      drop_q     <= '0;
    end else begin
      win_cnt <= wrap ? '0 : win_cnt + 1'b1;
      if (commit) begin
        commit_cnt <= (cnt_base == CNT_W'(FLOOD_LIMIT)) ? cnt_base : cnt_base + 1'b1;
        flood_q    <= flood_eff;
      end else begin
        commit_cnt <= cnt_base;
        flood_q    <= flood_base;
      end
      if (drop) drop_q <= sat_inc16(drop_q);
    end
  end

  assign flood_active = flood_q;
  assign drop_count   = drop_q;
`else
  assign guard_block  = 1'b0;
  assign flood_active = 1'b0;
  assign drop_count   = 16'd0;
`endif

  always_comb begin
    resp_c = RESP_OKAY;
    if (!in_range)        resp_c = RESP_DECERR;
    else if (!aligned)    resp_c = RESP_SLVERR;
    else if (guard_block) resp_c = RESP_SLVERR;
  end

  assign write_ok = commit && (resp_c == RESP_OKAY);

  // ---- commit stage -> registered B and memory port ----
  always_ff @(posedge clk_100MHz) begin
    if (reset_rtl_0) begin
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      mem_we <= write_ok;
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= resp_c;
      end else if (s_axi.bready) begin
        bvalid_q <= 1'b0;
      end
      if (write_ok) begin
        mem_addr  <= offset[MEM_AW+1:2];
        mem_wdata <= head_data;
        mem_wstrb <= head_strb;
      end
    end
  end

  assign s_axi.bvalid = bvalid_q;
  assign s_axi.bresp  = bresp_q;

  logic unused_ok;
  assign unused_ok = ^{head_prot, offset[ADDR_W-1:MEM_AW+2], offset[1:0],
                       FLOOD_WINDOW[0], FLOOD_LIMIT[0]};

endmodule

// File: tb/tb_axil_wr_responder.sv
module tb_axil_wr_responder;
  import axil_resp_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk_100MHz = 1'b0;
  logic        reset_rtl_0;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        flood_active;
  logic [15:0] drop_count;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [10:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } mw_t;

  logic [1:0] b_q[$];
  mw_t        m_q[$];

  always #5 clk_100MHz = ~clk_100MHz;

  axil_wr_if #(.ADDR_W(32), .DATA_W(32)) s_axi ();

  axil_wr_responder #(
    .ADDR_W(32), .DATA_W(32), .BASE_ADDR(32'h4000_0000), .MEM_WORDS(2048),
    .FIFO_DEPTH(4), .FLOOD_WINDOW(256), .FLOOD_LIMIT(64)
  ) dut (
    .clk_100MHz   (clk_100MHz),
    .reset_rtl_0  (reset_rtl_0),
    .s_axi        (s_axi),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .flood_active (flood_active),
    .drop_count   (drop_count)
  );

  // Record every B handshake and memory write in order.
  always @(negedge clk_100MHz) begin
    if (reset_rtl_0 === 1'b0) begin
      if (s_axi.bvalid === 1'b1 && s_axi.bready === 1'b1) b_q.push_back(s_axi.bresp);
      if (mem_we === 1'b1) m_q.push_back({mem_addr, mem_wdata, mem_wstrb});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one AW+W pair and return once both have handshaken (bounded).
  task automatic send_pair(input logic [31:0] a, input logic [2:0] p,
                           input logic [31:0] d, input logic [3:0] s);
    logic ag, wg;
    s_axi.awvalid = 1'b1; s_axi.awaddr = a; s_axi.awprot = p;
    s_axi.wvalid  = 1'b1; s_axi.wdata  = d; s_axi.wstrb  = s;
    for (int i = 0; i < 64 && (s_axi.awvalid || s_axi.wvalid); i++) begin
      @(negedge clk_100MHz);
      ag = s_axi.awvalid && s_axi.awready;
      wg = s_axi.wvalid && s_axi.wready;
      @(posedge clk_100MHz); #1;
      if (ag) s_axi.awvalid = 1'b0;
      if (wg) s_axi.wvalid  = 1'b0;
    end
    if (s_axi.awvalid || s_axi.wvalid) begin
      checks++;
      $display("FAIL send_pair_timeout addr=%h got=no handshake exp=handshake", a);
      s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset_rtl_0 = 1'b1;
    s_axi.awvalid = 1'b0; s_axi.awaddr = '0; s_axi.awprot = '0;
    s_axi.wvalid = 1'b0;  s_axi.wdata = '0;  s_axi.wstrb = '0;
    s_axi.bready = 1'b0;
    repeat (3) @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    checks++; if (s_axi.awready !== 1'b0) $display("FAIL rst_awready got=%b exp=0", s_axi.awready); else passed++;
    checks++; if (s_axi.wready !== 1'b0) $display("FAIL rst_wready got=%b exp=0", s_axi.wready); else passed++;
    checks++; if (s_axi.bvalid !== 1'b0) $display("FAIL rst_bvalid got=%b exp=0", s_axi.bvalid); else passed++;
    checks++; if (s_axi.bresp !== 2'b00) $display("FAIL rst_bresp got=%b exp=00", s_axi.bresp); else passed++;
    checks++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got=%b exp=0", mem_we); else passed++;
    checks++; if (mem_addr !== 11'd0) $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); else passed++;
    checks++; if (mem_wdata !== 32'd0) $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); else passed++;
    checks++; if (mem_wstrb !== 4'd0) $display("FAIL rst_mem_wstrb got=%h exp=0", mem_wstrb); else passed++;
    checks++; if (flood_active !== 1'b0) $display("FAIL rst_flood got=%b exp=0", flood_active); else passed++;
    checks++; if (drop_count !== 16'd0) $display("FAIL rst_drop got=%h exp=0", drop_count); else passed++;
    @(posedge clk_100MHz); #1;
    reset_rtl_0 = 1'b0;
    @(negedge clk_100MHz);
    checks++; if (s_axi.awready !== 1'b0) $display("FAIL rst_awready_last got=%b exp=0", s_axi.awready); else passed++;
    @(negedge clk_100MHz);
    checks++; if (s_axi.awready !== 1'b1) $display("FAIL post_rst_awready got=%b exp=1", s_axi.awready); else passed++;
    checks++; if (s_axi.wready !== 1'b1) $display("FAIL post_rst_wready got=%b exp=1", s_axi.wready); else passed++;
    @(posedge clk_100MHz); #1;
  endtask

  task automatic test_single;
    s_axi.bready = 1'b1;
    s_axi.awvalid = 1'b1; s_axi.awaddr = 32'h4000_0010; s_axi.awprot = 3'b000;
    s_axi.wvalid = 1'b1;  s_axi.wdata = 32'hCAFE_0001;  s_axi.wstrb = 4'hF;
    @(negedge clk_100MHz);
    checks++; if (s_axi.awready !== 1'b1) $display("FAIL single_awready got=%b exp=1", s_axi.awready); else passed++;
    @(posedge clk_100MHz); #1;
    s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
    @(negedge clk_100MHz);
    checks++; if (mem_we !== 1'b0) $display("FAIL single_we_c1 got=%b exp=0", mem_we); else passed++;
    checks++; if (s_axi.bvalid !== 1'b0) $display("FAIL single_bvalid_c1 got=%b exp=0", s_axi.bvalid); else passed++;
    @(posedge clk_100MHz); #1;
    @(negedge clk_100MHz);
    checks++; if (mem_we !== 1'b1) $display("FAIL single_we_c2 got=%b exp=1", mem_we); else passed++;
    checks++; if (mem_addr !== 11'd4) $display("FAIL single_addr got=%h exp=4", mem_addr); else passed++;
    checks++; if (mem_wdata !== 32'hCAFE_0001) $display("FAIL single_wdata got=%h exp=cafe0001", mem_wdata); else passed++;
    checks++; if (mem_wstrb !== 4'hF) $display("FAIL single_wstrb got=%h exp=f", mem_wstrb); else passed++;
    checks++; if (s_axi.bvalid !== 1'b1) $display("FAIL single_bvalid_c2 got=%b exp=1", s_axi.bvalid); else passed++;
    checks++; if (s_axi.bresp !== 2'b00) $display("FAIL single_bresp got=%b exp=00", s_axi.bresp); else passed++;
    @(posedge clk_100MHz); #1;
    @(negedge clk_100MHz);
    checks++; if (mem_we !== 1'b0) $display("FAIL single_we_c3 got=%b exp=0", mem_we); else passed++;
    checks++; if (s_axi.bvalid !== 1'b0) $display("FAIL single_bvalid_c3 got=%b exp=0", s_axi.bvalid); else passed++;
    @(posedge clk_100MHz); #1;
  endtask

  task automatic test_w_leads;
    s_axi.bready = 1'b1;
    s_axi.wvalid = 1'b1; s_axi.wdata = 32'hA000_0001; s_axi.wstrb = 4'hF;
    @(posedge clk_100MHz); #1; s_axi.wdata = 32'hA000_0002;
    @(posedge clk_100MHz); #1; s_axi.wdata = 32'hA000_0003;
    @(posedge clk_100MHz); #1;
    s_axi.wvalid = 1'b0;
    s_axi.awvalid = 1'b1; s_axi.awaddr = BASE + 32'h4; s_axi.awprot = 3'b000;
    @(negedge clk_100MHz);
    checks++; if (s_axi.bvalid !== 1'b0) $display("FAIL wl_bvalid_c3 got=%b exp=0", s_axi.bvalid); else passed++;
    @(posedge clk_100MHz); #1; s_axi.awaddr = BASE + 32'h8;
    @(negedge clk_100MHz);
    checks++; if (s_axi.bvalid !== 1'b0) $display("FAIL wl_bvalid_c4 got=%b exp=0", s_axi.bvalid); else passed++;
    @(posedge clk_100MHz); #1; s_axi.awaddr = BASE + 32'hC;
    @(negedge clk_100MHz);
    checks++; if (s_axi.bvalid !== 1'b1) $display("FAIL wl_bvalid_c5 got=%b exp=1", s_axi.bvalid); else passed++;
    checks++; if (mem_we !== 1'b1) $display("FAIL wl_we_c5 got=%b exp=1", mem_we); else passed++;
    checks++; if (mem_addr !== 11'd1) $display("FAIL wl_addr0 got=%h exp=1", mem_addr); else passed++;
    checks++; if (mem_wdata !== 32'hA000_0001) $display("FAIL wl_data0 got=%h exp=a0000001", mem_wdata); else passed++;
    @(posedge clk_100MHz); #1; s_axi.awvalid = 1'b0;
    @(negedge clk_100MHz);
    checks++; if (mem_addr !== 11'd2) $display("FAIL wl_addr1 got=%h exp=2", mem_addr); else passed++;
    checks++; if (mem_wdata !== 32'hA000_0002) $display("FAIL wl_data1 got=%h exp=a0000002", mem_wdata); else passed++;
    @(posedge clk_100MHz); #1;
    @(negedge clk_100MHz);
    checks++; if (mem_addr !== 11'd3) $display("FAIL wl_addr2 got=%h exp=3", mem_addr); else passed++;
    checks++; if (mem_wdata !== 32'hA000_0003) $display("FAIL wl_data2 got=%h exp=a0000003", mem_wdata); else passed++;
    checks++; if (s_axi.bresp !== 2'b00) $display("FAIL wl_bresp got=%b exp=00", s_axi.bresp); else passed++;
    @(posedge clk_100MHz); #1;
    @(negedge clk_100MHz);
    checks++; if (mem_we !== 1'b0) $display("FAIL wl_we_idle got=%b exp=0", mem_we); else passed++;
    checks++; if (s_axi.bvalid !== 1'b0) $display("FAIL wl_bvalid_idle got=%b exp=0", s_axi.bvalid); else passed++;
    @(posedge clk_100MHz); #1;
  endtask

  task automatic test_decode;
    logic [1:0] exp_r [4];
    exp_r[0] = 2'b11; exp_r[1] = 2'b10; exp_r[2] = 2'b11; exp_r[3] = 2'b00;
    s_axi.bready = 1'b1;
    b_q.delete(); m_q.delete();
    send_pair(32'h4000_2000, 3'b000, 32'h1111_1111, 4'hF);
    send_pair(32'h4000_0002, 3'b000, 32'h2222_2222, 4'hF);
    send_pair(32'h3FFF_FFFC, 3'b000, 32'h3333_3333, 4'hF);
    send_pair(32'h4000_1FFC, 3'b000, 32'h5555_AAAA, 4'h0);
    repeat (6) @(posedge clk_100MHz);
    #1;
    checks++; if (b_q.size() !== 4) $display("FAIL dec_b_count got=%0d exp=4", b_q.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      if (i < b_q.size()) begin
        checks++;
        if (b_q[i] !== exp_r[i]) $display("FAIL dec_bresp%0d got=%b exp=%b", i, b_q[i], exp_r[i]);
        else passed++;
      end
    end
    checks++; if (m_q.size() !== 1) $display("FAIL dec_we_count got=%0d exp=1", m_q.size()); else passed++;
    if (m_q.size() > 0) begin
      checks++; if (m_q[0].addr !== 11'h7FF) $display("FAIL dec_top_addr got=%h exp=7ff", m_q[0].addr); else passed++;
      checks++; if (m_q[0].strb !== 4'h0) $display("FAIL dec_zero_strb got=%h exp=0", m_q[0].strb); else passed++;
      checks++; if (m_q[0].data !== 32'h5555_AAAA) $display("FAIL dec_data got=%h exp=5555aaaa", m_q[0].data); else passed++;
    end
  endtask

  task automatic test_backpressure;
    int ok_n;
    bit in_order;
    s_axi.bready = 1'b0;
    b_q.delete(); m_q.delete();
    for (int i = 0; i < 5; i++) send_pair(BASE + 32'(4 * i), 3'b000, 32'h1000_0000 + 32'(i), 4'hF);
    repeat (2) @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    checks++; if (s_axi.awready !== 1'b0) $display("FAIL bp_awready_full got=%b exp=0", s_axi.awready); else passed++;
    checks++; if (s_axi.wready !== 1'b0) $display("FAIL bp_wready_full got=%b exp=0", s_axi.wready); else passed++;
    checks++; if (s_axi.bvalid !== 1'b1) $display("FAIL bp_bvalid_held got=%b exp=1", s_axi.bvalid); else passed++;
    checks++; if (m_q.size() !== 1) $display("FAIL bp_one_commit got=%0d exp=1", m_q.size()); else passed++;
    @(posedge clk_100MHz); #1;
    fork
      begin
        for (int i = 5; i < 10; i++) send_pair(BASE + 32'(4 * i), 3'b000, 32'h1000_0000 + 32'(i), 4'hF);
      end
      begin
        repeat (3) @(posedge clk_100MHz);
        #1; s_axi.bready = 1'b1;
      end
    join
    repeat (12) @(posedge clk_100MHz);
    #1;
    ok_n = 0;
    foreach (b_q[i]) if (b_q[i] === 2'b00) ok_n++;
    checks++; if (b_q.size() !== 10) $display("FAIL bp_b_count got=%0d exp=10", b_q.size()); else passed++;
    checks++; if (ok_n !== 10) $display("FAIL bp_okay_count got=%0d exp=10", ok_n); else passed++;
    in_order = (m_q.size() == 10);
    foreach (m_q[i])
      if (m_q[i].addr !== 11'(i) || m_q[i].data !== 32'h1000_0000 + 32'(i)) in_order = 1'b0;
    checks++; if (in_order !== 1'b1) $display("FAIL bp_order got=%0d writes/out-of-order exp=10 in order", m_q.size()); else passed++;
  endtask

  task automatic test_reset_mid;
    s_axi.bready = 1'b0;
    for (int i = 0; i < 4; i++) send_pair(BASE + 32'h40 + 32'(4 * i), 3'b000, 32'hDEAD_0000 + 32'(i), 4'h3);
    @(negedge clk_100MHz);
    checks++; if (s_axi.bvalid !== 1'b1) $display("FAIL rm_bvalid_pre got=%b exp=1", s_axi.bvalid); else passed++;
    @(posedge clk_100MHz); #1;
    reset_rtl_0 = 1'b1;
    @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    checks++; if (s_axi.bvalid !== 1'b0) $display("FAIL rm_bvalid got=%b exp=0", s_axi.bvalid); else passed++;
    checks++; if (s_axi.awready !== 1'b0) $display("FAIL rm_awready got=%b exp=0", s_axi.awready); else passed++;
    checks++; if (s_axi.wready !== 1'b0) $display("FAIL rm_wready got=%b exp=0", s_axi.wready); else passed++;
    checks++; if (mem_addr !== 11'd0) $display("FAIL rm_mem_addr got=%h exp=0", mem_addr); else passed++;
    checks++; if (mem_wdata !== 32'd0) $display("FAIL rm_mem_wdata got=%h exp=0", mem_wdata); else passed++;
    checks++; if (mem_wstrb !== 4'd0) $display("FAIL rm_mem_wstrb got=%h exp=0", mem_wstrb); else passed++;
    checks++; if (mem_we !== 1'b0) $display("FAIL rm_mem_we got=%b exp=0", mem_we); else passed++;
    @(posedge clk_100MHz); #1;
    reset_rtl_0 = 1'b0;
    s_axi.bready = 1'b1;
    b_q.delete(); m_q.delete();
    repeat (10) @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    checks++; if (b_q.size() !== 0) $display("FAIL rm_stray_b got=%0d exp=0", b_q.size()); else passed++;
    checks++; if (m_q.size() !== 0) $display("FAIL rm_stray_we got=%0d exp=0", m_q.size()); else passed++;
    checks++; if (s_axi.awready !== 1'b1) $display("FAIL rm_awready_after got=%b exp=1", s_axi.awready); else passed++;
    @(posedge clk_100MHz); #1;
  endtask

  task automatic test_flood;
    int ok_n;
    int slv_n;
    int waited;
    reset_rtl_0 = 1'b1;
    repeat (2) @(posedge clk_100MHz);
    #1; reset_rtl_0 = 1'b0;
    s_axi.bready = 1'b1;
    b_q.delete(); m_q.delete();
`ifdef AXIL_FLOOD_GUARD_EN
    for (int i = 0; i < 128; i++) send_pair(BASE + 32'(4 * i), 3'b000, 32'hBAD0_0000 + 32'(i), 4'hF);
    repeat (6) @(posedge clk_100MHz);
    #1;
    ok_n = 0; slv_n = 0;
    foreach (b_q[i]) begin
      if (i < 63 && b_q[i] === 2'b00) ok_n++;
      if (i >= 63 && b_q[i] === 2'b10) slv_n++;
    end
    checks++; if (b_q.size() !== 128) $display("FAIL fl_b_count got=%0d exp=128", b_q.size()); else passed++;
    checks++; if (ok_n !== 63) $display("FAIL fl_okay_first got=%0d exp=63", ok_n); else passed++;
    checks++; if (slv_n !== 65) $display("FAIL fl_slverr_rest got=%0d exp=65", slv_n); else passed++;
    checks++; if (m_q.size() !== 63) $display("FAIL fl_we_count got=%0d exp=63", m_q.size()); else passed++;
    checks++; if (drop_count !== 16'd65) $display("FAIL fl_drop got=%0d exp=65", drop_count); else passed++;
    checks++; if (flood_active !== 1'b1) $display("FAIL fl_active got=%b exp=1", flood_active); else passed++;
    b_q.delete(); m_q.delete();
    send_pair(BASE + 32'h100, 3'b001, 32'h600D_F00D, 4'hF);
    repeat (4) @(posedge clk_100MHz);
    #1;
    checks++; if (b_q.size() !== 1 || b_q[0] !== 2'b00) $display("FAIL fl_priv_resp got=%0d/%b exp=1/00", b_q.size(), (b_q.size() > 0) ? b_q[0] : 2'bxx); else passed++;
    checks++; if (m_q.size() !== 1) $display("FAIL fl_priv_we got=%0d exp=1", m_q.size()); else passed++;
    checks++; if (drop_count !== 16'd65) $display("FAIL fl_priv_drop got=%0d exp=65", drop_count); else passed++;
    waited = 0;
    while (flood_active === 1'b1 && waited < 300) begin
      @(negedge clk_100MHz);
      waited++;
    end
    checks++; if (flood_active !== 1'b0) $display("FAIL fl_wrap_clear got=%b exp=0", flood_active); else passed++;
    @(posedge clk_100MHz); #1;
    b_q.delete();
    send_pair(BASE + 32'h200, 3'b000, 32'h0000_0042, 4'hF);
    repeat (4) @(posedge clk_100MHz);
    #1;
    checks++; if (b_q.size() !== 1 || b_q[0] !== 2'b00) $display("FAIL fl_after_wrap got=%0d/%b exp=1/00", b_q.size(), (b_q.size() > 0) ? b_q[0] : 2'bxx); else passed++;
`else
    for (int i = 0; i < 80; i++) send_pair(BASE + 32'(4 * i), 3'b000, 32'hBAD0_0000 + 32'(i), 4'hF);
    repeat (6) @(posedge clk_100MHz);
    #1;
    ok_n = 0; slv_n = 0; waited = 0;
    foreach (b_q[i]) if (b_q[i] === 2'b00) ok_n++;
    checks++; if (ok_n !== 80) $display("FAIL nf_okay_count got=%0d exp=80", ok_n); else passed++;
    checks++; if (m_q.size() !== 80) $display("FAIL nf_we_count got=%0d exp=80", m_q.size()); else passed++;
    checks++; if (flood_active !== 1'b0) $display("FAIL nf_flood got=%b exp=0", flood_active); else passed++;
    checks++; if (drop_count !== 16'd0 || slv_n != waited) $display("FAIL nf_drop got=%0d exp=0", drop_count); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_w_leads();
    test_decode();
    test_backpressure();
    test_reset_mid();
    test_flood();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
